// File: rtl/md_pkg.sv
// Shared opcodes, FSM state type and sizing helper for the sequential multiply/divide unit.
package md_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    // Counter must hold 0..width inclusive.
    function automatic int unsigned cnt_width(input int unsigned width);
        return int'($clog2(width + 1));
    endfunction

endpackage

// File: rtl/seq_mul_div_if.sv
// Request/result bundle between the control unit and the multiply/divide unit.
interface seq_mul_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_zero;

    modport master (
        output start, op, input_a, input_b,
        input  busy, done, result_hi, result_lo, div_zero
    );

    modport slave (
        input  start, op, input_a, input_b,
        output busy, done, result_hi, result_lo, div_zero
    );
endinterface

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign correction.
module md_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result_c
);
    assign result_c = negate ? (~value + WIDTH'(1)) : value;
endmodule

// File: rtl/seq_mul_div.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit with HI/LO result.
// Optional macro MD_DIVZERO_FLAG_EN drives div_zero on a zero-divisor divide.
module seq_mul_div
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset,
    seq_mul_div_if.slave  md
);
    localparam int unsigned W     = WIDTH;
    localparam int unsigned AW    = 2 * WIDTH + 1;
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    md_state_e        state, state_n;
    logic             op_q;
    logic [W-1:0]     a_q, b_q;
    logic [AW-1:0]    acc;
    logic [CNT_W-1:0] cnt;
    logic             busy_q, done_q;
    logic [W-1:0]     hi_q, lo_q;

    logic             accept_c, load_c, step_c, fix_c;
    logic             busy_n, done_n;

    logic [W-1:0]     a_abs_c, b_abs_c, quot_c, rem_c;
    logic [W:0]       booth_sum_c, trial_c;
    logic [AW-1:0]    booth_next_c, div_shift_c, div_next_c;

    // Next-state and control strobes
    always_comb begin
        state_n  = state;
        accept_c = 1'b0;
        load_c   = 1'b0;
        step_c   = 1'b0;
        fix_c    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (md.start) begin
                    accept_c = 1'b1;
                    state_n  = RUN;
                end else begin
                    state_n  = IDLE;
                end
            end
            RUN: begin
                if (cnt == '0) load_c = 1'b1;
                else           step_c = 1'b1;
                if (cnt == CNT_W'(W)) state_n = FIX;
            end
            FIX: begin
                fix_c   = 1'b1;
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == RUN) || (state_n == FIX);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            busy_q <= busy_n;
            done_q <= done_n;
        end
    end

    md_sign_fix #(.WIDTH(W)) u_a_mag (.value(a_q), .negate(a_q[W-1]), .result_c(a_abs_c));
    md_sign_fix #(.WIDTH(W)) u_b_mag (.value(b_q), .negate(b_q[W-1]), .result_c(b_abs_c));
    md_sign_fix #(.WIDTH(W)) u_q_fix (.value(acc[W-1:0]), .negate(a_q[W-1] ^ b_q[W-1]),
                                      .result_c(quot_c));
    md_sign_fix #(.WIDTH(W)) u_r_fix (.value(acc[2*W-1:W]), .negate(a_q[W-1]), .result_c(rem_c));

    // Booth: acc = {A, Q, q_-1}; W+1-bit sum keeps the true sign for the arithmetic shift
    always_comb begin
        case (acc[1:0])
            2'b01:   booth_sum_c = {acc[AW-1], acc[AW-1:W+1]} + {a_q[W-1], a_q};
            2'b10:   booth_sum_c = {acc[AW-1], acc[AW-1:W+1]} - {a_q[W-1], a_q};
            default: booth_sum_c = {acc[AW-1], acc[AW-1:W+1]};
        endcase
        booth_next_c = {booth_sum_c, acc[W:1]};
    end

    // Restoring divide: acc = {R[W:0], Q[W-1:0]}
    always_comb begin
        div_shift_c = {acc[AW-2:0], 1'b0};
        trial_c     = div_shift_c[AW-1:W] - {1'b0, b_abs_c};
        div_next_c  = trial_c[W] ? div_shift_c : {trial_c, div_shift_c[W-1:1], 1'b1};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q <= OP_MUL;
            a_q  <= '0;
            b_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (accept_c) begin
                op_q <= md.op;
                a_q  <= md.input_a;
                b_q  <= md.input_b;
                cnt  <= '0;
            end else if (state == RUN) begin
                cnt  <= cnt + CNT_W'(1);
            end

            if (load_c) begin
                acc <= (op_q == OP_MUL) ? {{W{1'b0}}, b_q, 1'b0}
                                        : {{(W+1){1'b0}}, a_abs_c};
            end else if (step_c) begin
                acc <= (op_q == OP_MUL) ? booth_next_c : div_next_c;
            end

            if (fix_c) begin
                if (op_q == OP_MUL) begin
                    hi_q <= acc[AW-1:W+1];
                    lo_q <= acc[W:1];
                end else if (b_q == '0) begin
                    hi_q <= a_q;
                    lo_q <= '1;
                end else begin
                    hi_q <= rem_c;
                    lo_q <= quot_c;
                end
            end
        end
    end

`ifdef MD_DIVZERO_FLAG_EN
    logic dz_q;

    always_ff @(posedge clock) begin
        if (reset)         dz_q <= 1'b0;
        else if (accept_c) dz_q <= 1'b0;
        else if (fix_c)    dz_q <= (op_q == OP_DIV) && (b_q == '0);
    end

    assign md.div_zero = dz_q;
`else
    assign md.div_zero = 1'b0;
`endif

    assign md.busy      = busy_q;
    assign md.done      = done_q;
    assign md.result_hi = hi_q;
    assign md.result_lo = lo_q;

endmodule
